// File: rtl/uart_tx_pkg.sv
// Shared types and line-select codes for the UART transmit controller.
// The select codes must agree with the output mux in the Tx datapath.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] SEL_START  = 2'd0;
    localparam logic [1:0] SEL_IDLE   = 2'd1;
    localparam logic [1:0] SEL_DATA   = 2'd2;
    localparam logic [1:0] SEL_PARITY = 2'd3;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host handshake plus datapath control lines of the UART transmit controller.
// slave = the controller; master = host/datapath side driving it.
interface uart_tx_ctrl_if;
    logic       tx_start;
    logic       parity_en;
    logic       two_stop;
    logic       count_eq_size;
    logic       reg_en;
    logic       reset_reg;
    logic       reset_count;
    logic       count_en;
    logic [1:0] mux2_sl;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, parity_en, two_stop, count_eq_size,
        input  reg_en, reset_reg, reset_count, count_en, mux2_sl, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, parity_en, two_stop, count_eq_size,
        output reg_en, reset_reg, reset_count, count_en, mux2_sl, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Clocks-per-bit counter: wraps 0..CLKS_PER_BIT-1, tick on the last count.
// clear restarts the bit period so every state entry sees a full bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_ctrl.sv
// Frame sequencer for the UART transmit datapath: start, data LSB-first,
// optional parity, one or two stop bits, with start/busy/done handshake.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int N_DATA       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          resetn,
    uart_tx_ctrl_if.slave bus
);
    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
    end
    if (N_DATA < 1) begin : g_chk_ndata
        $error("uart_tx_ctrl: N_DATA must be at least 1");
    end

    tx_state_t state_q, state_d;
    logic      parity_en_q, parity_en_d;
    logic      two_stop_q, two_stop_d;
    logic      stop_idx_q, stop_idx_d;
    logic      bit_tick;
    logic      timer_clear;

    logic       reg_en_o;
    logic       reset_reg_o;
    logic       reset_count_o;
    logic       count_en_o;
    logic [1:0] mux2_sl_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_idx_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            parity_en_q <= parity_en_d;
            two_stop_q  <= two_stop_d;
            stop_idx_q  <= stop_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        parity_en_d   = parity_en_q;
        two_stop_d    = two_stop_q;
        stop_idx_d    = stop_idx_q;
        reg_en_o      = 1'b0;
        reset_reg_o   = 1'b1;
        reset_count_o = 1'b1;
        count_en_o    = 1'b0;
        mux2_sl_o     = SEL_IDLE;
        tx_busy_o     = 1'b1;
        tx_done_o     = 1'b0;

        case (state_q)
            IDLE: begin
                reset_count_o = 1'b0;
                tx_busy_o     = 1'b0;
                stop_idx_d    = 1'b0;
                if (bus.tx_start) begin
                    // Load the data register and latch the frame format together.
                    reg_en_o    = 1'b1;
                    parity_en_d = bus.parity_en;
                    two_stop_d  = bus.two_stop;
                    state_d     = START;
                end else begin
                    reset_reg_o = 1'b0;
                end
            end
            START: begin
                mux2_sl_o     = SEL_START;
                reset_count_o = 1'b0;
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                mux2_sl_o = SEL_DATA;
                if (bit_tick) begin
                    if (!bus.count_eq_size) begin
                        count_en_o = 1'b1;
                    end else begin
                        state_d = parity_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                mux2_sl_o = SEL_PARITY;
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q < two_stop_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        tx_done_o = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                reset_reg_o   = 1'b0;
                reset_count_o = 1'b0;
                tx_busy_o     = 1'b0;
            end
        endcase
    end

    // Holding the timer clear through IDLE guarantees START gets a full bit.
    assign timer_clear = (state_q == IDLE) || (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    assign bus.reg_en      = reg_en_o;
    assign bus.reset_reg   = reset_reg_o;
    assign bus.reset_count = reset_count_o;
    assign bus.count_en    = count_en_o;
    assign bus.mux2_sl     = mux2_sl_o;
    assign bus.tx_busy     = tx_busy_o;
    assign bus.tx_done     = tx_done_o;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a small Tx datapath model attached.
// CLKS_PER_BIT=4, N_DATA=8; outputs sampled on the falling edge.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
    localparam int ND  = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic [7:0] data_reg;
    logic [2:0] bit_cnt;
    logic       line_bit;

    int errors = 0;
    int checks = 0;

    int         r_len, r_cen, r_done, r_done_at, r_regen, r_nseg;
    logic [1:0] r_sel [8];
    int         r_slen[8];
    logic [11:0] r_line;

    typedef struct {
        logic        pe;
        logic        ts;
        logic [7:0]  data;
        bit          disturb;
        int          exp_len;
        int          exp_cen;
        int          exp_nseg;
        int          exp_stop_len;
        int          exp_nbits;
        logic [11:0] exp_line;
    } vec_t;

    uart_tx_ctrl_if bus_if ();

    uart_tx_ctrl #(
        .N_DATA      (ND),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Datapath model: data register, bit counter, bit-select/output mux, even parity.
    always_ff @(posedge clk) begin
        if (!bus_if.reset_reg) data_reg <= '0;
        else if (bus_if.reg_en) data_reg <= tx_data;
        if (!bus_if.reset_count) bit_cnt <= '0;
        else if (bus_if.count_en) bit_cnt <= bit_cnt + 3'd1;
    end

    assign bus_if.count_eq_size = (bit_cnt == 3'(ND - 1));

    always_comb begin
        line_bit = 1'b1;
        case (bus_if.mux2_sl)
            2'd0: line_bit = 1'b0;
            2'd1: line_bit = 1'b1;
            2'd2: line_bit = data_reg[bit_cnt];
            2'd3: line_bit = ^data_reg;
            default: line_bit = 1'b1;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic pe, input logic ts, input logic [7:0] d, input bit hold);
        @(negedge clk);
        bus_if.tx_start  = 1'b1;
        bus_if.parity_en = pe;
        bus_if.two_stop  = ts;
        tx_data          = d;
        #1;
        chk("accept_reg_en", bus_if.reg_en, 1);
        chk("accept_reset_reg", bus_if.reset_reg, 1);
        @(negedge clk);
        if (!hold) begin
            bus_if.tx_start  = 1'b0;
            bus_if.parity_en = 1'b0;
            bus_if.two_stop  = 1'b0;
        end
    endtask

    // Starts on a negedge inside the first busy cycle; returns at the first idle negedge.
    task automatic watch_frame(input bit disturb);
        int bi;
        r_len = 0; r_cen = 0; r_done = 0; r_done_at = 0; r_regen = 0; r_nseg = 0;
        r_line = '0;
        for (int g = 0; g < 200; g++) begin
            if (!bus_if.tx_busy) break;
            r_len++;
            if (bus_if.count_en) r_cen++;
            if (bus_if.tx_done) begin
                r_done++;
                r_done_at = r_len;
            end
            if (bus_if.reg_en) r_regen++;
            if (r_nseg == 0 || bus_if.mux2_sl != r_sel[r_nseg-1]) begin
                if (r_nseg < 8) begin
                    r_sel[r_nseg]  = bus_if.mux2_sl;
                    r_slen[r_nseg] = 1;
                    r_nseg++;
                end
            end else begin
                r_slen[r_nseg-1]++;
            end
            bi = (r_len - 1) / CPB;
            if ((r_len - 1) % CPB == CPB / 2 && bi < 12) r_line[bi] = line_bit;
            if (disturb) begin
                if (r_len >= 10 && r_len < 30) begin
                    bus_if.tx_start  = r_len[0];
                    bus_if.parity_en = r_len[1];
                    bus_if.two_stop  = r_len[2];
                end else begin
                    bus_if.tx_start  = 1'b0;
                    bus_if.parity_en = 1'b0;
                    bus_if.two_stop  = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("frame_ends", bus_if.tx_busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int si;
        logic [11:0] mask;
        start_frame(v.pe, v.ts, v.data, 1'b0);
        watch_frame(v.disturb);
        $display("frame %0d: pe=%0d ts=%0d data=%02h disturb=%0d len=%0d count_en=%0d done=%0d@%0d line=%03h",
                 idx, v.pe, v.ts, v.data, v.disturb, r_len, r_cen, r_done, r_done_at, r_line);
        chk("frame_len", r_len, v.exp_len);
        chk("count_en_pulses", r_cen, v.exp_cen);
        chk("done_pulses", r_done, 1);
        chk("done_last_cycle", r_done_at, v.exp_len);
        chk("reg_en_in_frame", r_regen, 0);
        chk("segment_count", r_nseg, v.exp_nseg);
        chk("start_sel", r_sel[0], 0);
        chk("start_len", r_slen[0], CPB);
        chk("data_sel", r_sel[1], 2);
        chk("data_len", r_slen[1], ND * CPB);
        if (v.pe) begin
            chk("parity_sel", r_sel[2], 3);
            chk("parity_len", r_slen[2], CPB);
        end
        si = v.pe ? 3 : 2;
        chk("stop_sel", r_sel[si], 1);
        chk("stop_len", r_slen[si], v.exp_stop_len);
        mask = 12'((1 << v.exp_nbits) - 1);
        chk("line_bits", int'(r_line & mask), int'(v.exp_line));
        chk("idle_mux", bus_if.mux2_sl, 1);
        chk("idle_done", bus_if.tx_done, 0);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{pe:1'b0, ts:1'b0, data:8'h3C, disturb:1'b0, exp_len:40, exp_cen:7,
                    exp_nseg:3, exp_stop_len:4, exp_nbits:10, exp_line:12'b0010_0111_1000};
        vecs[1] = '{pe:1'b1, ts:1'b1, data:8'h01, disturb:1'b0, exp_len:48, exp_cen:7,
                    exp_nseg:4, exp_stop_len:8, exp_nbits:12, exp_line:12'b1110_0000_0010};
        vecs[2] = '{pe:1'b1, ts:1'b0, data:8'hA5, disturb:1'b0, exp_len:44, exp_cen:7,
                    exp_nseg:4, exp_stop_len:4, exp_nbits:11, exp_line:12'b0101_0100_1010};
        vecs[3] = '{pe:1'b0, ts:1'b1, data:8'hFF, disturb:1'b0, exp_len:44, exp_cen:7,
                    exp_nseg:3, exp_stop_len:8, exp_nbits:11, exp_line:12'b0111_1111_1110};
        vecs[4] = '{pe:1'b0, ts:1'b0, data:8'h3C, disturb:1'b1, exp_len:40, exp_cen:7,
                    exp_nseg:3, exp_stop_len:4, exp_nbits:10, exp_line:12'b0010_0111_1000};

        resetn           = 1'b0;
        bus_if.tx_start  = 1'b0;
        bus_if.parity_en = 1'b0;
        bus_if.two_stop  = 1'b0;
        tx_data          = '0;
        repeat (3) @(negedge clk);
        chk("rst_mux", bus_if.mux2_sl, 1);
        chk("rst_busy", bus_if.tx_busy, 0);
        chk("rst_done", bus_if.tx_done, 0);
        chk("rst_count_en", bus_if.count_en, 0);
        chk("rst_reg_en", bus_if.reg_en, 0);
        chk("rst_reset_count", bus_if.reset_count, 0);
        chk("rst_reset_reg", bus_if.reset_reg, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
            repeat (2) @(negedge clk);
        end

        // Back-to-back with tx_start held high across the frame boundary.
        start_frame(1'b0, 1'b0, 8'h55, 1'b1);
        watch_frame(1'b0);
        $display("b2b frame 1: len=%0d done=%0d reg_en_in_frame=%0d", r_len, r_done, r_regen);
        chk("b2b_len1", r_len, 40);
        chk("b2b_regen1", r_regen, 0);
        chk("b2b_gap_busy", bus_if.tx_busy, 0);
        chk("b2b_gap_reg_en", bus_if.reg_en, 1);
        @(negedge clk);
        chk("b2b_restart_busy", bus_if.tx_busy, 1);
        chk("b2b_restart_sel", bus_if.mux2_sl, 0);
        bus_if.tx_start = 1'b0;
        watch_frame(1'b0);
        $display("b2b frame 2: len=%0d done=%0d reg_en_in_frame=%0d", r_len, r_done, r_regen);
        chk("b2b_len2", r_len, 40);
        chk("b2b_regen2", r_regen, 0);
        chk("b2b_done2", r_done, 1);
        repeat (2) @(negedge clk);

        // One-cycle reset in the middle of DATA, then a clean frame.
        start_frame(1'b1, 1'b1, 8'hC3, 1'b0);
        repeat (12) @(negedge clk);
        chk("pre_rst_in_data", bus_if.mux2_sl, 2);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        $display("mid-frame reset: mux=%0d busy=%0d done=%0d reset_count=%0d",
                 bus_if.mux2_sl, bus_if.tx_busy, bus_if.tx_done, bus_if.reset_count);
        chk("mrst_mux", bus_if.mux2_sl, 1);
        chk("mrst_busy", bus_if.tx_busy, 0);
        chk("mrst_done", bus_if.tx_done, 0);
        chk("mrst_reset_count", bus_if.reset_count, 0);
        chk("mrst_count_en", bus_if.count_en, 0);
        run_vec(vecs[0], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
